// File: rtl/trap_monitor_pkg.sv
// Shared types and constants for the trap monitor: state encoding, display modes,
// seven-segment glyphs (active-low, bit 7 = segment a ... bit 1 = g, bit 0 = dp).
package trap_monitor_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_ERROR = 2'd2
    } state_t;

    localparam logic [1:0] MODE_PC     = 2'd0;
    localparam logic [1:0] MODE_EPC    = 2'd1;
    localparam logic [1:0] MODE_CYCLES = 2'd2;
    localparam logic [1:0] MODE_CAUSE  = 2'd3;

    localparam logic [7:0] GLYPH_0 = 8'h03;
    localparam logic [7:0] GLYPH_1 = 8'h9F;
    localparam logic [7:0] GLYPH_2 = 8'h25;
    localparam logic [7:0] GLYPH_3 = 8'h0D;
    localparam logic [7:0] GLYPH_4 = 8'h99;
    localparam logic [7:0] GLYPH_5 = 8'h49;
    localparam logic [7:0] GLYPH_6 = 8'h41;
    localparam logic [7:0] GLYPH_7 = 8'h1F;
    localparam logic [7:0] GLYPH_8 = 8'h01;
    localparam logic [7:0] GLYPH_9 = 8'h09;
    localparam logic [7:0] GLYPH_A = 8'h11;
    localparam logic [7:0] GLYPH_B = 8'hC1;
    localparam logic [7:0] GLYPH_C = 8'h63;
    localparam logic [7:0] GLYPH_D = 8'h85;
    localparam logic [7:0] GLYPH_E = 8'h61;
    localparam logic [7:0] GLYPH_F = 8'h71;

    localparam logic [7:0] GLYPH_BLANK = 8'hFF;
    localparam logic [7:0] GLYPH_ERR   = 8'h6D;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic logic [3:0] lowest_set(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (vec[i]) idx = i[3:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/trap_monitor_hex_seg_enc.sv
// Combinational hex nibble to active-low seven-segment glyph encoder.
module hex_seg_enc
    import trap_monitor_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] seg
);

    always_comb begin
        seg = GLYPH_BLANK;
        case (nibble)
            4'h0: seg = GLYPH_0;
            4'h1: seg = GLYPH_1;
            4'h2: seg = GLYPH_2;
            4'h3: seg = GLYPH_3;
            4'h4: seg = GLYPH_4;
            4'h5: seg = GLYPH_5;
            4'h6: seg = GLYPH_6;
            4'h7: seg = GLYPH_7;
            4'h8: seg = GLYPH_8;
            4'h9: seg = GLYPH_9;
            4'hA: seg = GLYPH_A;
            4'hB: seg = GLYPH_B;
            4'hC: seg = GLYPH_C;
            4'hD: seg = GLYPH_D;
            4'hE: seg = GLYPH_E;
            4'hF: seg = GLYPH_F;
            default: seg = GLYPH_BLANK;
        endcase
    end

endmodule

// File: rtl/trap_monitor.sv
// Trap monitor: RUN/HALT/ERROR controller with cause/PC capture, cycle counter and hex display.
// Define TRAP_MONITOR_SCAN_EN for a time-multiplexed display; otherwise all digits drive in parallel.
module trap_monitor
    import trap_monitor_pkg::*;
#(
    parameter int unsigned           NUM_SRC    = 6,
    parameter logic [NUM_SRC-1:0]    FATAL_MASK = 6'b001111,
    parameter int unsigned           NUM_DIGITS = 8,
    parameter int unsigned           SCAN_DIV   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [63:0]               pc_i,
    input  logic [NUM_SRC-1:0]        irq_i,
    input  logic                      resume_i,
    input  logic [1:0]                mode_i,
    output logic                      run_o,
    output logic [1:0]                state_o,
    output logic [3:0]                cause_o,
    output logic [63:0]               epc_o,
    output logic [8*NUM_DIGITS-1:0]   segs_o,
    output logic [NUM_DIGITS-1:0]     an_o
);

    // state   | meaning
    // RUN     | core executing, cycle counter advancing
    // HALT    | stopped by a halt source, resume_i returns to RUN
    // ERROR   | stopped by a fatal source, left only through reset

    localparam int unsigned DISP_W = 4 * NUM_DIGITS;

    state_t              state_q, state_d;
    logic [3:0]          cause_q, cause_d;
    logic [63:0]         epc_q;
    logic [63:0]         cycles_q;
    logic                capture;

    logic [NUM_SRC-1:0]  fatal_irq, halt_irq;
    logic                fatal_hit, halt_hit;

    assign fatal_irq = irq_i & FATAL_MASK;
    assign halt_irq  = irq_i & ~FATAL_MASK;
    assign fatal_hit = |fatal_irq;
    assign halt_hit  = |halt_irq;

    // A pending halt source outranks resume_i, so HALT is held while one is asserted.
    always_comb begin
        state_d = state_q;
        if (fatal_hit)
            state_d = ST_ERROR;
        else if (state_q == ST_RUN && halt_hit)
            state_d = ST_HALT;
        else if (state_q == ST_HALT && resume_i && !halt_hit)
            state_d = ST_RUN;

        capture = (state_q != ST_ERROR) && (state_d != state_q) && (state_d != ST_RUN);
        cause_d = fatal_hit ? lowest_set(16'(fatal_irq)) : lowest_set(16'(halt_irq));
    end

    assign run_o = (state_d == ST_RUN);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_RUN;
            cause_q  <= 4'd0;
            epc_q    <= 64'd0;
            cycles_q <= 64'd0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                cause_q <= cause_d;
                epc_q   <= pc_i;
            end
            if (state_q == ST_RUN)
                cycles_q <= cycles_q + 64'd1;
        end
    end

    assign state_o = state_q;
    assign cause_o = cause_q;
    assign epc_o   = epc_q;

    logic [63:0]         src_val;
    logic [DISP_W-1:0]   nib_vec;
    logic                unused_src;

    always_comb begin
        src_val = pc_i;
        case (mode_i)
            MODE_PC:     src_val = pc_i;
            MODE_EPC:    src_val = epc_q;
            MODE_CYCLES: src_val = cycles_q;
            MODE_CAUSE:  src_val = {60'd0, cause_q};
            default:     src_val = pc_i;
        endcase
        nib_vec = src_val[DISP_W-1:0];
        // In ERROR digit 0 always carries the cause, whatever mode is selected.
        if (state_q == ST_ERROR)
            nib_vec[3:0] = cause_q;
    end

    assign unused_src = ^src_val;

    logic [8*NUM_DIGITS-1:0] segs_d;
    logic [NUM_DIGITS-1:0]   an_d;

`ifdef TRAP_MONITOR_SCAN_EN
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int unsigned DIV_W = $clog2(SCAN_DIV);

    logic [IDX_W-1:0] idx_q;
    logic [DIV_W-1:0] div_q;
    logic [3:0]       scan_nib;
    logic [7:0]       scan_glyph;
    logic [7:0]       scan_byte;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q <= DIV_W'(SCAN_DIV - 1);
            idx_q <= '0;
        end else if (div_q == '0) begin
            div_q <= DIV_W'(SCAN_DIV - 1);
            idx_q <= (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            div_q <= div_q - 1'b1;
        end
    end

    assign scan_nib = nib_vec[4*int'(idx_q) +: 4];

    hex_seg_enc u_enc (
        .nibble (scan_nib),
        .seg    (scan_glyph)
    );

    always_comb begin
        scan_byte = scan_glyph;
        if (state_q == ST_ERROR) begin
            if (idx_q == IDX_W'(NUM_DIGITS - 1))
                scan_byte = GLYPH_ERR;
            else if (idx_q != '0)
                scan_byte = GLYPH_BLANK;
        end
        segs_d        = '1;
        segs_d[7:0]   = scan_byte;
        an_d          = '1;
        an_d[idx_q]   = 1'b0;
    end
`else
    logic [8*NUM_DIGITS-1:0] glyph_vec;

    for (genvar k = 0; k < NUM_DIGITS; k++) begin : g_digit
        hex_seg_enc u_enc (
            .nibble (nib_vec[4*k +: 4]),
            .seg    (glyph_vec[8*k +: 8])
        );
    end

    always_comb begin
        segs_d = glyph_vec;
        if (state_q == ST_ERROR) begin
            segs_d      = '1;
            segs_d[7:0] = glyph_vec[7:0];
            segs_d[8*(NUM_DIGITS-1) +: 8] = GLYPH_ERR;
        end
        an_d = '0;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            segs_o <= '1;
            an_o   <= '1;
        end else begin
            segs_o <= segs_d;
            an_o   <= an_d;
        end
    end

endmodule

// File: tb/tb_trap_monitor.sv
// Directed self-checking bench for trap_monitor (default parameters, SCAN_DIV=4).
module tb_trap_monitor;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [63:0] pc_i;
    logic [5:0]  irq_i;
    logic        resume_i;
    logic [1:0]  mode_i;
    logic        run_o;
    logic [1:0]  state_o;
    logic [3:0]  cause_o;
    logic [63:0] epc_o;
    logic [63:0] segs_o;
    logic [7:0]  an_o;

    int checks = 0;
    int errors = 0;

    trap_monitor #(
        .NUM_SRC    (6),
        .FATAL_MASK (6'b001111),
        .NUM_DIGITS (8),
        .SCAN_DIV   (4)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .pc_i     (pc_i),
        .irq_i    (irq_i),
        .resume_i (resume_i),
        .mode_i   (mode_i),
        .run_o    (run_o),
        .state_o  (state_o),
        .cause_o  (cause_o),
        .epc_o    (epc_o),
        .segs_o   (segs_o),
        .an_o     (an_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        pc_i     = 64'h8000_0000;
        irq_i    = '0;
        resume_i = 1'b0;
        mode_i   = 2'd0;
        tick();
        tick();
        chk("rst_state", 64'(state_o), 64'd0);
        chk("rst_cause", 64'(cause_o), 64'd0);
        chk("rst_epc",   epc_o,        64'd0);
        chk("rst_segs",  segs_o,       64'hFFFF_FFFF_FFFF_FFFF);
        chk("rst_an",    64'(an_o),    64'hFF);
        chk("rst_run",   64'(run_o),   64'd1);
        rst_ni = 1'b1;
        tick();
`ifndef TRAP_MONITOR_SCAN_EN
        chk("pc_disp", segs_o,     64'h0103_0303_0303_0303);
        chk("an_par",  64'(an_o),  64'h00);
`endif
        chk("run_idle", 64'(run_o), 64'd1);

        // Halt source 5, then resume
        pc_i  = 64'h8000_0010;
        irq_i = 6'b100000;
        #1 chk("run_drop_comb", 64'(run_o), 64'd0);
        tick();
        irq_i = '0;
        chk("halt_state", 64'(state_o), 64'd1);
        chk("halt_epc",   epc_o,        64'h8000_0010);
        chk("halt_cause", 64'(cause_o), 64'd5);
        chk("halt_run",   64'(run_o),   64'd0);
        resume_i = 1'b1;
        #1 chk("resume_run_comb", 64'(run_o), 64'd1);
        tick();
        resume_i = 1'b0;
        chk("resume_state", 64'(state_o), 64'd0);

        // Two halt sources: lowest index captured; halt irq beats resume in HALT
        pc_i  = 64'h1234;
        irq_i = 6'b110000;
        tick();
        irq_i = '0;
        chk("halt2_state", 64'(state_o), 64'd1);
        chk("halt2_cause", 64'(cause_o), 64'd4);
        pc_i     = 64'h5678;
        irq_i    = 6'b010000;
        resume_i = 1'b1;
        tick();
        irq_i    = '0;
        resume_i = 1'b0;
        chk("irq_beats_resume", 64'(state_o), 64'd1);
        chk("no_recapture_epc", epc_o,        64'h1234);
        resume_i = 1'b1;
        tick();
        resume_i = 1'b0;
        chk("resume2_state", 64'(state_o), 64'd0);

        // Fatal and halt together -> ERROR, cause = lowest fatal
        pc_i  = 64'h8000_0020;
        irq_i = 6'b100110;
        tick();
        irq_i = '0;
        chk("err_state", 64'(state_o), 64'd2);
        chk("err_cause", 64'(cause_o), 64'd1);
        chk("err_epc",   epc_o,        64'h8000_0020);
        resume_i = 1'b1;
        tick();
        resume_i = 1'b0;
        chk("err_sticky",  64'(state_o), 64'd2);
        chk("err_run",     64'(run_o),   64'd0);
        irq_i = 6'b100000;
        tick();
        irq_i = '0;
        chk("err_halt_irq_state", 64'(state_o), 64'd2);
        chk("err_halt_irq_cause", 64'(cause_o), 64'd1);
`ifndef TRAP_MONITOR_SCAN_EN
        chk("err_disp", segs_o, 64'h6DFF_FFFF_FFFF_FF9F);
`endif

        // Asynchronous reset out of ERROR
        rst_ni = 1'b0;
        #1;
        chk("async_rst_state", 64'(state_o), 64'd0);
        chk("async_rst_segs",  segs_o,       64'hFFFF_FFFF_FFFF_FFFF);
        tick();
        rst_ni = 1'b1;

        // HALT, then fatal with resume in same cycle -> ERROR, cause 0
        pc_i  = 64'hAA;
        irq_i = 6'b100000;
        tick();
        irq_i = '0;
        chk("halt3_state", 64'(state_o), 64'd1);
        pc_i     = 64'hBB;
        irq_i    = 6'b000001;
        resume_i = 1'b1;
        #1 chk("fatal_resume_run", 64'(run_o), 64'd0);
        tick();
        irq_i    = '0;
        resume_i = 1'b0;
        chk("fatal_resume_state", 64'(state_o), 64'd2);
        chk("fatal_resume_cause", 64'(cause_o), 64'd0);
        chk("fatal_resume_epc",   epc_o,        64'hBB);

        // Reset out of ERROR; run_o tracks irq right after release
        rst_ni = 1'b0;
        tick();
        tick();
        rst_ni = 1'b1;
        mode_i = 2'd2;
        irq_i  = 6'b100000;
        #1 chk("post_rst_run_irq", 64'(run_o), 64'd0);
        irq_i = '0;
        #1 chk("post_rst_run_idle", 64'(run_o), 64'd1);

        // Cycle counter: 9 clean RUN edges + halting edge = 10
        repeat (9) tick();
        pc_i  = 64'hFFFF_FFFF_A000_00E2;
        irq_i = 6'b100000;
        tick();
        irq_i = '0;
        chk("cyc_halt_state", 64'(state_o), 64'd1);
        chk("cyc_halt_epc",   epc_o,        64'hFFFF_FFFF_A000_00E2);
        tick();
`ifndef TRAP_MONITOR_SCAN_EN
        chk("cyc_disp", segs_o, 64'h0303_0303_0303_0311);
        repeat (5) tick();
        chk("cyc_hold", segs_o, 64'h0303_0303_0303_0311);
        mode_i = 2'd3;
        tick();
        chk("cause_disp", segs_o, 64'h0303_0303_0303_0349);
        mode_i = 2'd1;
        tick();
        chk("epc_disp", segs_o, 64'h1103_0303_0303_6125);
`endif

`ifdef TRAP_MONITOR_SCAN_EN
        // Scan: digit index advances every 4 edges, wraps after 32
        rst_ni = 1'b0;
        mode_i = 2'd0;
        pc_i   = 64'h8000_0000;
        tick();
        rst_ni = 1'b1;
        for (int k = 1; k <= 36; k++) begin
            int         idx;
            logic [7:0] exp_an;
            logic [7:0] exp_byte;
            tick();
            idx         = ((k - 1) / 4) % 8;
            exp_an      = 8'hFF;
            exp_an[idx] = 1'b0;
            exp_byte    = (idx == 7) ? 8'h01 : 8'h03;
            chk("scan_an",   64'(an_o), 64'(exp_an));
            chk("scan_segs", segs_o,    {56'hFF_FFFF_FFFF_FFFF, exp_byte});
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_monitor.md
TRAP_MONITOR -- requirements
Module: trap_monitor

Interface
REQ-001 Parameter NUM_SRC, default 6: number of trap/interrupt source lines, range 2..16.
REQ-002 Parameter FATAL_MASK, default 6'b001111: bit i set marks source i fatal (ERROR); clear marks it a halt source (HALT).
REQ-003 Parameter NUM_DIGITS, default 8: seven-segment digits driven, range 1..16.
REQ-004 Parameter SCAN_DIV, default 1024: cycles per digit in scan mode, at least 2.
REQ-005 clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-006 rst_ni  in  1  reset, asynchronous assert, active-low.
REQ-007 pc_i  in  64  current core PC.
REQ-008 irq_i  in  NUM_SRC  level trap requests from fetch/decode/execute.
REQ-009 resume_i  in  1  single-cycle pulse; leaves HALT.
REQ-010 mode_i  in  2  display select: 0 PC, 1 captured PC, 2 cycle count, 3 cause.
REQ-011 run_o  in-core PC write enable, out 1, high when next state is RUN.
REQ-012 state_o  out  2  registered state: 0 RUN, 1 HALT, 2 ERROR.
REQ-013 cause_o  out  4  captured source index; epc_o  out  64  captured PC.
REQ-014 segs_o  out  8*NUM_DIGITS  active-low segment bytes, digit k in bits [8k+7:8k].
REQ-015 an_o  out  NUM_DIGITS  active-low digit enables.

Function
REQ-016 Next state: any fatal irq bit -> ERROR; else any halt irq bit while RUN -> HALT; else HALT with resume_i -> RUN; otherwise hold.
REQ-017 ERROR is sticky; only reset leaves it; resume_i ignored in ERROR.
REQ-018 Fatal and halt sources asserted together -> ERROR; irq and resume_i together in HALT -> irq wins.
REQ-019 Multiple qualifying sources -> cause_o captures lowest index among the winning class.
REQ-020 Capture of cause_o/epc_o (epc_o = pc_i) on every RUN->HALT, RUN->ERROR or HALT->ERROR transition, same edge as the state change.
REQ-021 run_o combinational: (next state == RUN); an irq in RUN deasserts run_o the same cycle.
REQ-022 64-bit cycle counter increments each cycle in RUN, holds in HALT/ERROR, wraps 2^64-1 -> 0.
REQ-023 Display value = lowest 4*NUM_DIGITS bits of mode-selected source; digit k shows nibble k as hex glyph.
REQ-024 Glyphs active-low: 0=8'h03, 1=8'h9F, 2=8'h25, 8=8'h01, A=8'h11, E=8'h61; blank=8'hFF; error glyph=8'h6D.
REQ-025 In ERROR, mode_i ignored: digit 0 shows cause nibble, top digit shows error glyph, others blank.
REQ-026 segs_o registered: reflects state/value sampled one cycle earlier (latency 1).

Reset
REQ-027 On rst_ni low: state RUN, cause_o 0, epc_o 0, counter 0, segs_o all 8'hFF, an_o all ones, scan index 0.
REQ-028 Reset mid-HALT or mid-ERROR returns to RUN immediately; run_o follows irq_i after release.

Configuration
REQ-029 Macro TRAP_MONITOR_SCAN_EN defined: time-multiplexed drive; only active digit's byte valid on segs_o[7:0], others 8'hFF; an_o one-hot-low advancing every SCAN_DIV cycles, wrapping NUM_DIGITS-1 -> 0.
REQ-030 Macro undefined: all digits driven in parallel, an_o held all zeros, no scan counter synthesised.

Structure
REQ-031 Shared package holds state enum, glyph constants, blank/error glyph, mode encodings.
REQ-032 One sub-module, hex_seg_enc: 4-bit nibble to active-low glyph, combinational, instantiated per digit (once when scanning).

Verification
REQ-033 Reset, pc_i=64'h80000000, mode 0 -> after 1 cycle segs_o digit7=8'h01, digits0..6=8'h03, run_o=1.
REQ-034 irq_i[5] (halt) one cycle at pc 0x80000010 -> state_o=1, epc_o=0x80000010, cause_o=5, run_o=0; resume_i -> state_o=0.
REQ-035 irq_i[1] and irq_i[2] together -> state_o=2, cause_o=1; resume_i ignored; digit0=8'h9F, digit7=8'h6D.
REQ-036 In HALT, irq_i[0] with resume_i same cycle -> ERROR, cause_o=0.
REQ-037 Mode 2, 10 RUN cycles then halt -> display value 10 (digit0=8'hA glyph 8'h11) held while halted.
REQ-038 SCAN_EN, SCAN_DIV=4, NUM_DIGITS=8 -> an_o low bit rotates 0..7 every 4 cycles, wraps to 0 after 32.
